// File: rtl/spi_temp_reader.sv
// spi_temp_reader: SPI mode-0 master reading one 16-bit sensor frame and clamping its integer field to 0..99
module spi_temp_reader #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        valid,
    output logic [6:0]  temp_bin,
    output logic        temp_neg,
    output logic        temp_ovr,
    output logic [15:0] raw_frame
);
    localparam logic [2:0] IDLE = 3'd0, LOW = 3'd1, HIGH = 3'd2, HOLD = 3'd3, DONE = 3'd4;
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [4:0] NBITS = 5'(FRAME_BITS);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bits_q, bits_d;
    logic [15:0] shift_q, shift_d, raw_q, raw_d;
    logic [6:0]  bin_q, bin_d;
    logic        sclk_q, sclk_d, cs_n_q, cs_n_d, busy_q, busy_d, valid_q, valid_d;
    logic        neg_q, neg_d, ovr_q, ovr_d;
    logic        tick, timed;
    logic [6:0]  field;

    assign tick  = cnt_q == DIV_M1;
    assign timed = state_q == LOW || state_q == HIGH || state_q == HOLD;
    assign field = shift_q[14:8];

    always_comb begin
        state_d = state_q;
        cnt_d   = timed ? (tick ? 8'd0 : cnt_q + 8'd1) : 8'd0;
        bits_d  = bits_q;
        shift_d = shift_q;
        raw_d   = raw_q;
        bin_d   = bin_q;
        neg_d   = neg_q;
        ovr_d   = ovr_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOW;
                cs_n_d  = 1'b0;
                busy_d  = 1'b1;
                bits_d  = 5'd0;
            end
            LOW: if (tick) begin
                state_d = HIGH;
                sclk_d  = 1'b1;
                shift_d = {shift_q[14:0], spi_miso};
                bits_d  = bits_q + 5'd1;
            end
            HIGH: if (tick) begin
                sclk_d  = 1'b0;
                state_d = bits_q == NBITS ? HOLD : LOW;
            end
            HOLD: if (tick) begin
                state_d = DONE;
                cs_n_d  = 1'b1;
                valid_d = 1'b1;
                raw_d   = shift_q;
                neg_d   = shift_q[15];
                ovr_d   = !shift_q[15] && field > 7'd99;
                bin_d   = shift_q[15] ? 7'd0 : (field > 7'd99 ? 7'd99 : field);
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bits_q  <= 5'd0;
            shift_q <= 16'd0;
            raw_q   <= 16'd0;
            bin_q   <= 7'd0;
            neg_q   <= 1'b0;
            ovr_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            raw_q   <= raw_d;
            bin_q   <= bin_d;
            neg_q   <= neg_d;
            ovr_q   <= ovr_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign temp_bin  = bin_q;
    assign temp_neg  = neg_q;
    assign temp_ovr  = ovr_q;
    assign raw_frame = raw_q;
endmodule

// File: tb/tb_spi_temp_reader.sv
// tb_spi_temp_reader: table-driven frames through a behavioural sensor, plus reset and back-to-back sequences
module tb_spi_temp_reader;
    logic        clk = 0, reset = 1, start = 0, spi_miso;
    logic        spi_sclk, spi_cs_n, busy, valid, temp_neg, temp_ovr;
    logic [6:0]  temp_bin;
    logic [15:0] raw_frame, frame_tb = 16'h0, sh = 16'h0;
    int          cyc = 0, total = 0, bad = 0;

    spi_temp_reader #(.CLK_DIV(4), .FRAME_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .spi_miso(spi_miso),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .busy(busy), .valid(valid),
        .temp_bin(temp_bin), .temp_neg(temp_neg), .temp_ovr(temp_ovr), .raw_frame(raw_frame)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor: loads its frame when selected, moves to the next bit on each SCLK fall
    always @(negedge spi_cs_n) sh = frame_tb;
    always @(negedge spi_sclk) sh = {sh[14:0], 1'b0};
    assign spi_miso = sh[15];

    typedef struct {
        logic [15:0] frame;
        int          bin;
        bit          neg;
        bit          ovr;
        int          pulse_at;
    } vec_t;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from E0 to E0+133; pulse_at>0 re-pulses start mid-frame, keep leaves start high
    task automatic xfer(input logic [15:0] f, input int pulse_at, input bit keep, output int e0);
        int rises, badr, vcnt, vat, lowc, unstable;
        logic ps;
        logic [6:0] b0;
        logic [15:0] r0;
        logic n0, o0;
        b0 = temp_bin; r0 = raw_frame; n0 = temp_neg; o0 = temp_ovr;
        frame_tb = f;
        start = 1;
        step();
        e0 = cyc;
        chk("cs_fall_at_e0", int'(spi_cs_n), 0);
        start = keep;
        rises = 0; badr = 0; vcnt = 0; vat = -1; lowc = 1; unstable = 0; ps = 0;
        for (int i = 1; i <= 133; i++) begin
            step();
            if (spi_sclk && !ps) begin
                rises++;
                if (cyc - e0 != (2 * rises - 1) * 4) badr++;
            end
            ps = spi_sclk;
            if (!spi_cs_n) lowc++;
            if (valid) begin vcnt++; vat = cyc - e0; end
            else if (vcnt == 0 && (temp_bin != b0 || raw_frame != r0 || temp_neg != n0 || temp_ovr != o0)) unstable++;
            if (i == 132) chk("busy_at_valid", int'(busy), 1);
            if (i == 133) chk("busy_low_after", int'(busy), 0);
            if (pulse_at > 0 && i == pulse_at) start = 1;
            if (pulse_at > 0 && i == pulse_at + 1) start = keep;
        end
        chk("sclk_rises", rises, 16);
        chk("sclk_rise_timing", badr, 0);
        chk("cs_low_cycles", lowc, 132);
        chk("valid_count", vcnt, 1);
        chk("valid_at", vat, 132);
        chk("results_stable", unstable, 0);
        chk("raw_frame", int'(raw_frame), int'(f));
    endtask

    initial begin
        vec_t v[7];
        int e0, e1, rises;
        logic ps;
        v[0] = '{16'h1980, 25, 0, 0, 0};
        v[1] = '{16'h7F00, 99, 0, 1, 0};
        v[2] = '{16'h6300, 99, 0, 0, 0};
        v[3] = '{16'h8C00, 0, 1, 0, 0};
        v[4] = '{16'h6400, 99, 0, 1, 40};
        v[5] = '{16'h0000, 0, 0, 0, 0};
        v[6] = '{16'hFFFF, 0, 1, 0, 0};

        start = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_cs_n", int'(spi_cs_n), 1);
            chk("rst_sclk", int'(spi_sclk), 0);
            chk("rst_busy_valid", int'({busy, valid}), 0);
            chk("rst_results", int'({temp_bin, temp_neg, temp_ovr, raw_frame}), 0);
        end
        start = 0;
        reset = 0;
        step();
        chk("idle_cs_n", int'(spi_cs_n), 1);

        foreach (v[k]) begin
            xfer(v[k].frame, v[k].pulse_at, 0, e0);
            chk("temp_bin", int'(temp_bin), v[k].bin);
            chk("temp_neg", int'(temp_neg), int'(v[k].neg));
            chk("temp_ovr", int'(temp_ovr), int'(v[k].ovr));
            step();
        end

        xfer(16'h1980, 0, 1, e0);
        xfer(16'h2F80, 0, 0, e1);
        chk("b2b_gap", e1 - e0, 134);
        chk("b2b_bin", int'(temp_bin), 47);
        step();

        frame_tb = 16'h5500;
        start = 1;
        step();
        start = 0;
        rises = 0; ps = 0;
        for (int i = 0; i < 100 && rises < 7; i++) begin
            step();
            if (spi_sclk && !ps) rises++;
            ps = spi_sclk;
        end
        chk("reached_7_rises", rises, 7);
        reset = 1;
        step();
        reset = 0;
        chk("abort_cs_n", int'(spi_cs_n), 1);
        chk("abort_sclk", int'(spi_sclk), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_results", int'({temp_bin, raw_frame}), 0);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid || !spi_cs_n) rises++;
        end
        chk("abort_quiet", rises, 0);

        xfer(16'h2A00, 0, 0, e0);
        chk("after_abort_bin", int'(temp_bin), 42);
        chk("after_abort_flags", int'({temp_neg, temp_ovr}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_temp_reader.md
Name: spi_temp_reader

Overview:
SPI mode-0 master that reads one 16-bit frame from the temperature sensor on request. It extracts the integer-degree field and clamps it to 0..99. It drives the 7-bit binary temperature that feeds the binary-to-BCD converter, plus status flags for the display path. Sits directly upstream of the BCD stage.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (legal range 1..255); full SCLK period is 2*CLK_DIV clk cycles.
FRAME_BITS, 16, SCLK cycles per transaction; the field positions below assume 16.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request one read; sampled only in IDLE.
spi_miso  input  1  serial data from sensor, MSB first.
spi_sclk  output  1  SPI clock, idle low, registered.
spi_cs_n  output  1  chip select, active low, registered.
busy  output  1  high from the start-accept edge until return to IDLE.
valid  output  1  one-cycle pulse when new results are loaded.
temp_bin  output  7  clamped integer temperature 0..99, unsigned binary; goes to the BCD stage `bin` input.
temp_neg  output  1  latched: last frame had sign bit set.
temp_ovr  output  1  latched: last frame integer field exceeded 99.
raw_frame  output  16  last complete received frame, unmodified.

Behaviour:
- Reset (synchronous, active-high; wins over every other input in the same cycle):
  - Outputs: spi_cs_n=1, spi_sclk=0, busy=0, valid=0, temp_bin=0, temp_neg=0, temp_ovr=0, raw_frame=0.
  - Internals: state=IDLE, shift register, bit counter and divider counter cleared.
  - Reset mid-transaction aborts it immediately: no valid, partial data discarded.
- States: IDLE, LOW, HIGH, HOLD, DONE. Divider counter counts 0..CLK_DIV-1 in LOW, HIGH and HOLD.
- Transitions (E0 = edge on which start is sampled high in IDLE):
  - IDLE: on start=1, go to LOW; drive spi_cs_n<=0, busy<=1, bit counter<=0.
  - LOW (sclk=0): after CLK_DIV cycles, go to HIGH.
    - Same edge: spi_sclk<=1, shift in spi_miso at the LSB, increment bit counter.
  - HIGH (sclk=1): after CLK_DIV cycles, spi_sclk<=0.
    - If FRAME_BITS bits are received, go to HOLD; else go to LOW.
  - HOLD: spi_cs_n stays 0 for CLK_DIV cycles, then go to DONE; drive spi_cs_n<=1.
    - On the same edge, load raw_frame, temp_bin, temp_neg and temp_ovr, and set valid<=1.
  - DONE: one cycle, then go to IDLE; valid<=0, busy<=0.
- Timing:
  - spi_cs_n falls at E0.
  - Exactly FRAME_BITS SCLK rising edges, the k-th at E0+(2k-1)*CLK_DIV.
  - Last SCLK falling edge at E0+32*CLK_DIV.
  - spi_cs_n rises and valid asserts at E0+33*CLK_DIV.
  - busy deasserts at E0+33*CLK_DIV+1.
- MISO sampling: spi_miso is sampled on the clk edge that raises spi_sclk. The sensor changes data on the SCLK falling edge. No input synchronizer; spi_miso is constrained stable for ≥1 clk before each rising edge.
- Frame decode: bit15=sign, bits14:8=integer °C, bits7:0=fraction (ignored).
  - sign=1: temp_bin=0, temp_neg=1, temp_ovr=0.
  - sign=0 and field>99: temp_bin=99, temp_ovr=1, temp_neg=0.
  - Otherwise: temp_bin=field, both flags 0.
- Result outputs hold their values between transactions and change only on the valid edge.
- start while busy (LOW/HIGH/HOLD/DONE) is ignored and not queued.
- start held high continuously gives back-to-back transactions, with exactly one IDLE cycle between DONE and the next spi_cs_n fall.

Test Plan:
1. Reset for 2 cycles, with start=1 during reset -> all outputs at reset values, spi_cs_n=1 and no SCLK activity during reset.
2. CLK_DIV=4, sensor model returns 0x1980 -> spi_cs_n low for 132 cycles, 16 SCLK rising edges each 8 cycles apart, valid pulses once at E0+132, temp_bin=25, temp_neg=0, temp_ovr=0, raw_frame=0x1980.
3. Frame 0x7F00 -> temp_bin=99, temp_ovr=1, temp_neg=0; then frame 0x6300 -> temp_bin=99, temp_ovr=0.
4. Frame 0x8C00 -> temp_bin=0, temp_neg=1, temp_ovr=0, raw_frame=0x8C00.
5. Pulse start again at E0+40 (during busy) -> ignored, exactly one valid pulse. Then hold start high -> second spi_cs_n fall at E0+134, with previous results stable until the second valid.
6. Assert reset after the 7th SCLK rising edge -> next cycle spi_cs_n=1, spi_sclk=0, busy=0, no valid. A following start with frame 0x2A00 -> temp_bin=42.
